// File: rtl/serial_subtractor_32.sv
// Bit-serial two's-complement subtractor: difference = a + ~b + 1,
// DIGIT bits per clock, LSB first, with start/busy/done handshake and
// carryout/overflow/zero flags matching the combinational ripple adder.
`timescale 1ns/1ps

module serial_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res_sh;
  logic              carry;
  logic [CW-1:0]     count;

  logic [DIGIT-1:0]  digit_sum;
  logic              digit_cout;
  logic              digit_cin_msb;
  logic              ripple;
  logic [WIDTH-1:0]  next_res;

  // Ripple-add the low digit of both shift registers plus the stored carry,
  // remembering the carry that enters the top bit of the digit so the final
  // digit can supply carry-into-MSB for the overflow flag.
  always_comb begin
    ripple        = carry;
    digit_sum     = '0;
    digit_cin_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) digit_cin_msb = ripple;
      digit_sum[i] = a_sh[i] ^ b_sh[i] ^ ripple;
      ripple       = (a_sh[i] & b_sh[i]) | (ripple & (a_sh[i] ^ b_sh[i]));
    end
    digit_cout = ripple;
  end

  // Sum digits enter at the top so after N steps the first digit sits at the LSB.
  assign next_res = {digit_sum, res_sh[WIDTH-1:DIGIT]};

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      carryout   <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= ~b;
            res_sh <= '0;
            carry  <= 1'b1;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= next_res;
          carry  <= digit_cout;
          count  <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            difference <= next_res;
            carryout   <= digit_cout;
            overflow   <= digit_cout ^ digit_cin_msb;
            zero       <= ~|next_res;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
